logic_l4_sum_dec: RTL and testbench

- Receive-side decoder for the running-sum stream: input is the raw accumulated sum, one word per transfer.
- It recovers each per-transfer increment by modular difference against the previously accepted sum.
- Results go through a 2-entry output buffer with valid/ready flow control, plus a count of decoded words.
- Sits downstream of the accumulator stage; it is the inverse of "sum <= sum + data".

---
 rtl/logic_l4_sum_dec_if.sv | 24 ++
 rtl/logic_l4_sum_dec.sv | 73 +++++++
 tb/tb_logic_l4_sum_dec.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_l4_sum_dec_if.sv
// rtl/logic_l4_sum_dec_if.sv - running-sum decoder stream/handshake bundle
interface logic_l4_sum_dec_if #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_CNT_BITS  = 16
);
    logic                     ib_clear;
    logic [PAR_DATA_BITS-1:0] ivG_sum;
    logic                     ib_valid;
    logic                     ob_ready;
    logic [PAR_DATA_BITS-1:0] ovG_data;
    logic                     ob_valid;
    logic                     ib_ready;
    logic [PAR_CNT_BITS-1:0]  ovG_count;

    modport slave (
        input  ib_clear, ivG_sum, ib_valid, ib_ready,
        output ob_ready, ovG_data, ob_valid, ovG_count
    );

    modport master (
        output ib_clear, ivG_sum, ib_valid, ib_ready,
        input  ob_ready, ovG_data, ob_valid, ovG_count
    );
endinterface

// File: rtl/logic_l4_sum_dec.sv
// rtl/logic_l4_sum_dec.sv - running-sum stream decoder with 2-entry output buffer
module logic_l4_sum_dec #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_CNT_BITS  = 16
) (
    input  logic                  ib_clk,
    input  logic                  ib_rst,
    logic_l4_sum_dec_if.slave     bus
);
    logic [PAR_DATA_BITS-1:0] prev_q;
    logic [PAR_DATA_BITS-1:0] mem_q [2];
    logic [PAR_DATA_BITS-1:0] last_q;
    logic                     wr_ptr_q;
    logic                     rd_ptr_q;
    logic [1:0]               fill_q;
    logic [PAR_CNT_BITS-1:0]  cnt_q;

    logic                     ready;
    logic                     valid;
    logic                     acc;
    logic                     pop;
    logic [PAR_DATA_BITS-1:0] delta;

    // Handshake outputs come straight from the fill register, so there is
    // no combinational path from ib_valid or ib_ready back to ob_ready.
    assign ready = ~fill_q[1];
    assign valid = (fill_q != 2'd0);
    assign acc   = bus.ib_valid & ready;
    assign pop   = valid & bus.ib_ready;

    // A clear in the same cycle as an accept decodes against a zero reference.
    assign delta = bus.ivG_sum - (bus.ib_clear ? {PAR_DATA_BITS{1'b0}} : prev_q);

    assign bus.ob_ready  = ready;
    assign bus.ob_valid  = valid;
    assign bus.ovG_data  = valid ? mem_q[rd_ptr_q] : last_q;
    assign bus.ovG_count = cnt_q;

    always_ff @(posedge ib_clk or negedge ib_rst) begin
        if (!ib_rst) begin
            prev_q   <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
            cnt_q    <= '0;
        end else begin
            if (acc) begin
                mem_q[wr_ptr_q] <= delta;
                wr_ptr_q        <= ~wr_ptr_q;
                prev_q          <= bus.ivG_sum;
                cnt_q           <= bus.ib_clear ? PAR_CNT_BITS'(1) : cnt_q + 1'b1;
            end else if (bus.ib_clear) begin
                prev_q <= '0;
                cnt_q  <= '0;
            end

            // Remember the word just drained so ovG_data holds steady when empty.
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                last_q   <= mem_q[rd_ptr_q];
            end

            case ({acc, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_l4_sum_dec.sv
// tb/tb_logic_l4_sum_dec.sv - self-checking bench for logic_l4_sum_dec
module tb_logic_l4_sum_dec;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_l4_sum_dec_if #(.PAR_DATA_BITS(8), .PAR_CNT_BITS(16)) bus ();

    logic_l4_sum_dec #(.PAR_DATA_BITS(8), .PAR_CNT_BITS(16)) dut (
        .ib_clk (clk),
        .ib_rst (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  m_prev = 8'h00;
    logic [15:0] m_cnt  = 16'h0000;

    typedef struct {
        logic [7:0]  sum;
        logic        clr;
        logic [7:0]  exp_data;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: model consumes what the DUT will see at this edge, then checks flags.
    task automatic tick();
        logic       a;
        logic       p;
        logic [7:0] d;
        a = bus.ib_valid & bus.ob_ready;
        p = bus.ob_valid & bus.ib_ready;
        if (p) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected actual=%0h required=none", bus.ovG_data);
            end else begin
                d = exp_q.pop_front();
                total--;
                chk("pop_data", bus.ovG_data, d);
            end
        end
        if (a) begin
            d = bus.ivG_sum - (bus.ib_clear ? 8'h00 : m_prev);
            exp_q.push_back(d);
            m_prev = bus.ivG_sum;
            m_cnt  = bus.ib_clear ? 16'd1 : m_cnt + 16'd1;
        end else if (bus.ib_clear) begin
            m_prev = 8'h00;
            m_cnt  = 16'h0000;
        end
        @(posedge clk);
        #1;
        chk("ob_ready", bus.ob_ready, (exp_q.size() < 2) ? 1 : 0);
        chk("ob_valid", bus.ob_valid, (exp_q.size() > 0) ? 1 : 0);
        chk("count", bus.ovG_count, m_cnt);
    endtask

    task automatic send(input logic [7:0] s, input logic c);
        logic ok;
        ok = 1'b0;
        bus.ib_valid = 1'b1;
        bus.ivG_sum  = s;
        bus.ib_clear = c;
        for (int i = 0; i < 16 && !ok; i++) begin
            ok = bus.ob_ready;
            tick();
        end
        bus.ib_valid = 1'b0;
        bus.ib_clear = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted sum=%0h", s);
        end
    endtask

    task automatic drain();
        bus.ib_ready = 1'b1;
        bus.ib_valid = 1'b0;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        vecs[0] = '{8'h03, 1'b0, 8'h03, 16'd1};
        vecs[1] = '{8'h08, 1'b0, 8'h05, 16'd2};
        vecs[2] = '{8'h10, 1'b0, 8'h08, 16'd3};
        vecs[3] = '{8'hF0, 1'b0, 8'hE0, 16'd4};
        vecs[4] = '{8'h10, 1'b0, 8'h20, 16'd5};
        vecs[5] = '{8'h10, 1'b0, 8'h00, 16'd6};
        vecs[6] = '{8'h40, 1'b0, 8'h30, 16'd7};
        vecs[7] = '{8'h07, 1'b1, 8'h07, 16'd1};
        vecs[8] = '{8'h09, 1'b0, 8'h02, 16'd2};

        bus.ib_clear = 1'b0;
        bus.ivG_sum  = 8'h00;
        bus.ib_valid = 1'b0;
        bus.ib_ready = 1'b1;

        #1;
        chk("rst_ready", bus.ob_ready, 1);
        chk("rst_valid", bus.ob_valid, 0);
        chk("rst_count", bus.ovG_count, 0);
        chk("rst_data", bus.ovG_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Table vectors: each word presented the cycle after its accept
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].sum, vecs[i].clr);
            chk("vec_valid", bus.ob_valid, 1);
            chk("vec_data", bus.ovG_data, vecs[i].exp_data);
            chk("vec_count", bus.ovG_count, vecs[i].exp_cnt);
        end
        drain();

        // Backpressure: two accepts fill the buffer, third word is held
        bus.ib_clear = 1'b1;
        tick();
        bus.ib_clear = 1'b0;
        bus.ib_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        chk("bp_full", bus.ob_ready, 0);
        bus.ib_valid = 1'b1;
        bus.ivG_sum  = 8'h06;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_held_count", bus.ovG_count, 2);
        bus.ib_ready = 1'b1;
        for (int i = 0; i < 8 && bus.ib_valid; i++) begin
            if (bus.ob_ready) begin
                tick();
                bus.ib_valid = 1'b0;
            end else begin
                tick();
            end
        end
        chk("bp_accepted", bus.ib_valid, 0);
        drain();

        // Steady push+pop at fill level 1
        bus.ib_ready = 1'b1;
        bus.ib_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.ivG_sum = 8'($urandom);
            tick();
            chk("stream_ready", bus.ob_ready, 1);
        end
        bus.ib_valid = 1'b0;
        drain();

        // Random handshake traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            logic a;
            if (!bus.ib_valid) begin
                bus.ib_valid = ($urandom % 4) != 0;
                bus.ivG_sum  = 8'($urandom);
            end
            bus.ib_ready = ($urandom % 3) != 0;
            bus.ib_clear = ($urandom % 16) == 0;
            a = bus.ib_valid & bus.ob_ready;
            tick();
            if (a) bus.ib_valid = 1'b0;
        end
        bus.ib_clear = 1'b0;
        bus.ib_valid = 1'b0;
        drain();

        // Asynchronous reset with two words buffered
        bus.ib_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        chk("pre_rst_full", bus.ob_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.ob_valid, 0);
        chk("arst_count", bus.ovG_count, 0);
        chk("arst_ready", bus.ob_ready, 1);
        exp_q.delete();
        m_prev = 8'h00;
        m_cnt  = 16'h0000;
        #3;
        rst_n = 1'b1;
        bus.ib_ready = 1'b1;
        send(8'h05, 1'b0);
        chk("post_rst_data", bus.ovG_data, 8'h05);
        chk("post_rst_count", bus.ovG_count, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
